div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle divider sequencer for the EX stage of the five-stage MIPS core. It accepts a DIV/DIVU request from EX and runs a 32-iteration radix-2 restoring divide. It returns {remainder, quotient} for the HI/LO write path and raises a stall request toward CTRL until the result is ready. This block is the only owner of the divide datapath, and EX holds its request stable while stalled.

## Interface
- No parameters. Operand width is fixed at 32 and result width at 64.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  divide request from EX; held high by EX while stalled.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  32  dividend (rs).
- opdata2_i  in  32  divisor (rt).
- annul_i  in  1  cancel the in-flight divide (pipeline flush).
- result_o  out  64  [63:32] remainder (HI), [31:0] quotient (LO).
- ready_o  out  1  result_o valid.
- stallreq_o  out  1  stall request to CTRL; combinational.

## Operation
- States: IDLE, BYZERO, BUSY, DONE. There is a 6-bit iteration counter cnt.
- IDLE:
  - start_i=1 and annul_i=0 and opdata2_i=0 → BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i≠0 → BUSY, with cnt=0.
  - On entry to BUSY, latch |opdata1_i| and |opdata2_i| when signed_i=1, or the raw values otherwise.
  - Latch both operand signs and signed_i at the same time.
- BUSY: one shift-subtract iteration per cycle.
  - Partial remainder is 33 bits: trial = {rem[31:0], dividend_msb} − {1'b0, divisor}.
  - If the trial result is non-negative, shift in quotient bit 1 and keep the trial value. Otherwise shift in 0 and keep the unsubtracted value.
  - After cnt reaches 31, go to DONE on the next edge.
  - annul_i=1 → IDLE on the next edge and discard partial state.
- BYZERO: one cycle, then go to DONE with quotient=0 and remainder=0.
- DONE: ready_o=1 and result_o is the final value.
  - Signed fix-up is applied when entering DONE.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Stay in DONE while start_i=1 and annul_i=0. result_o and ready_o hold stable.
  - start_i=0 or annul_i=1 → IDLE on the next edge. ready_o falls with the state change.
- stallreq_o = start_i & ~annul_i & (state≠DONE).
- Arithmetic is two's-complement modulo 2^32. 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0, with no trap.
- A new request is accepted only in IDLE. Operand changes while BUSY or DONE are ignored.

## Timing
- Reset: state=IDLE, cnt=0, ready_o=0, result_o=0, and all internal registers are 0. stallreq_o follows its equation with state=IDLE.
- Reset asserted mid-divide aborts the divide. The state is IDLE on the next cycle.
- Normal divide, with start_i first high in cycle 0:
  - Cycles 1..32 are BUSY.
  - DONE and ready_o=1 in cycle 33.
  - stallreq_o is high in cycles 0..32 and low from cycle 33.
- Divide by zero: BYZERO in cycle 1, DONE in cycle 2. stallreq_o is high in cycles 0..1.
- Start-to-ready latency is 33 cycles for a normal divide and 2 cycles for divide by zero.
- annul_i in cycle k with BUSY → IDLE in cycle k+1. stallreq_o is low from cycle k, because annul_i gates it combinationally.
- start_i and annul_i both high in IDLE: the request is not accepted.
- Back-to-back divides: after DONE, start_i must drop for at least one cycle, which the EX advance guarantees. The next request is accepted in IDLE.

## Test plan
- DIVU 100 / 7 → ready_o rises in cycle 33 with result_o = {0x00000002, 0x0000000E}. stallreq_o is high for exactly cycles 0..32.
- DIV −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD and remainder 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000 and remainder 0.
- DIVU 5 / 0 → ready_o in cycle 2 with result_o = 0. stallreq_o is high only in cycles 0..1.
- DIVU 0xFFFFFFFF / 3 with annul_i pulsed in cycle 10:
  - Expect IDLE in cycle 11, ready_o never asserted, and stallreq_o low in cycle 10.
  - A new DIVU 9 / 4 started in cycle 12 yields {1, 2} in cycle 45.
- Hold start_i high 5 cycles past DONE → result_o and ready_o are stable throughout. Drop start_i → ready_o=0 on the next cycle.
- Assert rst in cycle 15 of a divide → cycle 16 is IDLE with ready_o=0 and result_o=0. A subsequent DIVU 0x10 / 0x10 gives {0, 1}.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the EX stage.
//
// This block accepts a DIV/DIVU request, runs 32 shift-subtract iterations,
// and returns {remainder, quotient} for the HI/LO write path. While a divide
// is outstanding, it holds a stall request toward CTRL.
//
// Ports:
//   clk         core clock
//   rst         synchronous, active-high reset
//   start_i     divide request from EX; EX holds it high while stalled
//   signed_i    1 = DIV (signed), 0 = DIVU
//   opdata1_i   dividend (rs)
//   opdata2_i   divisor (rt)
//   annul_i     cancel the in-flight divide (pipeline flush)
//   result_o    [63:32] remainder (HI), [31:0] quotient (LO)
//   ready_o     result_o valid
//   stallreq_o  combinational stall request to CTRL
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        BUSY   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] rem_q, rem_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        signed_q, signed_d;
    logic [63:0] result_q, result_d;

    // Datapath for one iteration. Quotient bits shift into the dividend
    // register as the dividend bits shift out, so after 32 steps that
    // register holds the unsigned quotient.
    logic [32:0] trial;
    logic [31:0] quot_step;
    logic [31:0] rem_step;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    always_comb begin
        trial     = {rem_q, dividend_q[31]} - {1'b0, divisor_q};
        quot_step = {dividend_q[30:0], ~trial[32]};
        rem_step  = trial[32] ? {rem_q[30:0], dividend_q[31]} : trial[31:0];

        // The quotient is negative when the operand signs differ. The
        // remainder follows the dividend sign. Unsigned divides skip both.
        quot_fix = (signed_q && (sign_a_q ^ sign_b_q)) ? (32'd0 - quot_step) : quot_step;
        rem_fix  = (signed_q && sign_a_q) ? (32'd0 - rem_step) : rem_step;

        abs_a = (signed_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
        abs_b = (signed_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
    end

    // Next-state logic. A new request is taken only in IDLE. An annul
    // discards all partial state, so a flushed divide leaves nothing behind.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        signed_d   = signed_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d    = BUSY;
                        cnt_d      = 6'd0;
                        rem_d      = 32'd0;
                        dividend_d = abs_a;
                        divisor_d  = abs_b;
                        sign_a_d   = opdata1_i[31];
                        sign_b_d   = opdata2_i[31];
                        signed_d   = signed_i;
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    result_d = 64'd0;
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_d    = IDLE;
                    cnt_d      = 6'd0;
                    rem_d      = 32'd0;
                    dividend_d = 32'd0;
                    divisor_d  = 32'd0;
                    sign_a_d   = 1'b0;
                    sign_b_d   = 1'b0;
                    signed_d   = 1'b0;
                end else begin
                    dividend_d = quot_step;
                    rem_d      = rem_step;
                    cnt_d      = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DONE;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end
            DONE: begin
                if (!start_i || annul_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset clears everything, including the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            rem_q      <= 32'd0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            signed_q   <= 1'b0;
            result_q   <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            signed_q   <= signed_d;
            result_q   <= result_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = (state_q == DONE);
    assign stallreq_o = start_i & ~annul_i & (state_q != DONE);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq.
// It combines directed cases with randomized divides and checks every result
// against an arithmetic reference model.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks;
    int passes;

    div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from the division rules with plain arithmetic.
    // Operands are widened to 64 bits so that -2^31 / -1 cannot overflow.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic        negA;
        logic        negB;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] q;
        logic [63:0] r;
        if (b == 32'd0) return 64'd0;
        negA = sgn && a[31];
        negB = sgn && b[31];
        ua = negA ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        ub = negB ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q = ua / ub;
        r = ua % ub;
        if (negA != negB) q = 64'd0 - q;
        if (negA) r = 64'd0 - r;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic applyStimulus(input logic st, input logic sg, input logic [31:0] a,
                                 input logic [31:0] b, input logic an);
        start_i   = st;
        signed_i  = sg;
        opdata1_i = a;
        opdata2_i = b;
        annul_i   = an;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Move to the start of the next cycle, just after the active edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Run one divide starting in the current cycle (cycle 0). In every cycle
    // the task checks the {ready, stall} pair, and it checks the result when
    // ready first rises. It then keeps start high for hold extra cycles,
    // drops start, and checks that ready falls on the next cycle.
    task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        logic [63:0] exp;
        exp = refDiv(sgn, a, b);
        lat = (b == 32'd0) ? 2 : 33;
        applyStimulus(1'b1, sgn, a, b, 1'b0);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            checkOutput({tag, "_rdy_stall"}, {62'd0, ready_o, stallreq_o},
                        {62'd0, (c == lat), (c < lat)});
            if (c == lat) checkOutput({tag, "_result"}, result_o, exp);
            nextCycle();
            // Operand changes while busy must not disturb the divide.
            opdata1_i = $urandom;
            opdata2_i = $urandom;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_rdy"}, {63'd0, ready_o}, 64'd1);
            checkOutput({tag, "_hold_res"}, result_o, exp);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_drop_rdy"}, {63'd0, ready_o}, 64'd1);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, "_idle_rdy"}, {63'd0, ready_o}, 64'd0);
        nextCycle();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        checks = 0;
        passes = 0;

        // Reset state.
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
        checkOutput("reset_result", result_o, 64'd0);
        checkOutput("reset_stall", {63'd0, stallreq_o}, 64'd0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        // Directed cases.
        runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
        runDiv("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 0);
        runDiv("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, 0);

        // Annul mid-divide. Start high in cycle 0, annul in cycle 10.
        applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 32'd3, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("annul_pre", {62'd0, ready_o, stallreq_o}, 64'd1);
            nextCycle();
        end
        annul_i = 1'b1;
        @(negedge clk);
        checkOutput("annul_c10", {62'd0, ready_o, stallreq_o}, 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("annul_c11", {62'd0, ready_o, stallreq_o}, 64'd0);
        nextCycle();
        runDiv("divu_9_4_after_annul", 1'b0, 32'd9, 32'd4, 0);

        // Hold start five cycles past DONE.
        runDiv("divu_hold", 1'b0, 32'd1000, 32'd33, 5);

        // start and annul together in IDLE must not be accepted. A
        // divide-by-zero started next cycle then shows its 2-cycle latency.
        applyStimulus(1'b1, 1'b0, 32'd77, 32'd5, 1'b1);
        @(negedge clk);
        checkOutput("start_annul_idle", {62'd0, ready_o, stallreq_o}, 64'd0);
        nextCycle();
        runDiv("divu_after_reject", 1'b0, 32'd8, 32'd0, 0);

        // Reset in cycle 15 of a divide.
        applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 32'd3, 1'b0);
        for (int c = 0; c < 15; c++) nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        checkOutput("rst_mid_result", result_o, 64'd0);
        nextCycle();
        runDiv("divu_10_10", 1'b0, 32'h10, 32'h10, 0);

        // Randomized divides, with some corner operands mixed in.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = {28'd0, rb[3:0]} + 32'd1;
                2: ra = 32'h80000000;
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            runDiv("rand", rs, ra, rb, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
